// File: rtl/ram4x3_fifo_ctrl.sv
// FIFO controller wrapping a 4x3 single-port RAM plus a one-word output register.
// Optional: define RAM4X3_FIFO_BYPASS_EN to load words straight into the output register when the RAM is empty.
module ram4x3_fifo_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamDataIn,
    output logic              RamWrite,
    input  logic [DATA_W-1:0] RamDataOut,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // Handshake: a word moves on a rising Clk edge only when the sender's
    // valid and the receiver's ready are both high in that cycle; a sender
    // holds its word stable until it is taken.
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              load;
    logic              accept;
    logic              bypass;
    logic              write;

    always_comb begin
        load    = (Count != '0) && (!OutValid || OutReady);
        InReady = !Full && !load && !Rst;
        accept  = InValid && InReady;
`ifdef RAM4X3_FIFO_BYPASS_EN
        bypass  = accept && (Count == '0) && (!OutValid || OutReady);
`else
        bypass  = 1'b0;
`endif
        write   = accept && !bypass;
    end

    assign Full  = (Count == DEPTH);
    assign Empty = (Count == '0) && !OutValid;

    // The single RAM port serves either the prefetch read or the write, never both.
    always_comb begin
        RamAddr   = wr_ptr;
        RamDataIn = InData;
        RamWrite  = 1'b0;
        if (Rst) begin
            RamAddr   = '0;
            RamDataIn = '0;
        end else if (load) begin
            RamAddr = rd_ptr;
        end else if (write) begin
            RamWrite = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            OutValid <= 1'b0;
            OutData  <= '0;
        end else begin
            if (load) begin
                OutData  <= RamDataOut;
                OutValid <= 1'b1;
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (bypass) begin
                OutData  <= InData;
                OutValid <= 1'b1;
            end else if (OutValid && OutReady) begin
                OutValid <= 1'b0;
            end
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            Count <= Count + (ADDR_W+1)'(write) - (ADDR_W+1)'(load);
        end
    end

endmodule

// File: tb/tb_ram4x3_fifo_ctrl.sv
// Directed bench for ram4x3_fifo_ctrl with a behavioural 4x3 RAM and an ordered scoreboard.
module tb_ram4x3_fifo_ctrl;

    logic       Clk;
    logic       Rst;
    logic       InValid;
    logic       InReady;
    logic [2:0] InData;
    logic       OutValid;
    logic       OutReady;
    logic [2:0] OutData;
    logic [1:0] RamAddr;
    logic [2:0] RamDataIn;
    logic       RamWrite;
    logic [2:0] RamDataOut;
    logic [2:0] Count;
    logic       Full;
    logic       Empty;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [2:0] exp_q[$];
    logic [1:0] m_wr;
    logic [2:0] mem [4];

    ram4x3_fifo_ctrl #(.ADDR_W(2), .DATA_W(3)) dut (
        .Clk(Clk), .Rst(Rst),
        .InValid(InValid), .InReady(InReady), .InData(InData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .RamAddr(RamAddr), .RamDataIn(RamDataIn), .RamWrite(RamWrite),
        .RamDataOut(RamDataOut),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    // Companion RAM: synchronous write, asynchronous read.
    always @(posedge Clk) if (RamWrite) mem[RamAddr] <= RamDataIn;
    assign RamDataOut = mem[RamAddr];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every word taken by the consumer must be the oldest one pushed.
    always @(negedge Clk) begin
        if (!Rst && OutValid && OutReady) begin
            chk("pop_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("pop_data", OutData, exp_q.pop_front());
                pops++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [2:0] d);
        bit done = 0;
        InValid = 1'b1;
        InData  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge Clk);
            if (InReady) begin
`ifndef RAM4X3_FIFO_BYPASS_EN
                chk("push_we", RamWrite, 1);
                chk("push_addr", RamAddr, m_wr);
                m_wr = m_wr + 2'd1;
`endif
                exp_q.push_back(d);
                done = 1;
            end
            next_cycle();
        end
        chk("push_accepted", done, 1);
        InValid = 1'b0;
    endtask

    task automatic wait_empty();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            if (Empty) seen = 1;
            next_cycle();
        end
        chk("drain_empty", seen, 1);
        chk("drain_q_left", exp_q.size(), 0);
    endtask

    initial begin
        Rst = 1'b1; InValid = 1'b1; InData = 3'b101; OutReady = 1'b0; m_wr = 2'd0;

        // Reset held for two cycles with a pending producer word.
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("rst_we", RamWrite, 0);
            chk("rst_inready", InReady, 0);
            chk("rst_addr", RamAddr, 0);
            chk("rst_din", RamDataIn, 0);
            next_cycle();
        end
        Rst = 1'b0; InValid = 1'b0;
        @(negedge Clk);
        chk("rst_count", Count, 0);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_outdata", OutData, 0);
        chk("rst_full", Full, 0);
        next_cycle();

        // Fill with the consumer stalled.
        push(3'b101);
        push(3'b010);
        push(3'b111);
        push(3'b000);
        @(negedge Clk);
        chk("fill_outvalid", OutValid, 1);
        chk("fill_outdata", OutData, 3'b101);
        chk("fill_count3", Count, 3);
        next_cycle();
        push(3'b011);
        @(negedge Clk);
        chk("fill_count4", Count, 4);
        chk("fill_full", Full, 1);
        chk("fill_inready", InReady, 0);
        next_cycle();
        InValid = 1'b1; InData = 3'b110;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("full_refuse_rdy", InReady, 0);
            chk("full_refuse_we", RamWrite, 0);
            next_cycle();
        end
        InValid = 1'b0;
        @(negedge Clk);
        chk("full_count_held", Count, 4);
        next_cycle();

        // Drain: expect 101, 010, 111, 000, 011.
        OutReady = 1'b1;
        wait_empty();
        chk("drain_pops", pops, 5);
        chk("drain_count", Count, 0);
        chk("drain_outvalid", OutValid, 0);
        OutReady = 1'b0;

        // Wrap: ten words in mixed bursts; pointers roll over 3->0.
        push(3'd0); push(3'd1); push(3'd2);
        OutReady = 1'b1;
        push(3'd3); push(3'd4); push(3'd5); push(3'd6);
        OutReady = 1'b0;
        push(3'd7); push(3'd0);
        OutReady = 1'b1;
        push(3'd1);
        wait_empty();
        chk("wrap_pops", pops, 15);
        OutReady = 1'b0;

        // Simultaneous push and pop at Count=2: the prefetch read wins.
        push(3'b001); push(3'b010); push(3'b011);
        @(negedge Clk);
        chk("sim_count2", Count, 2);
        next_cycle();
        InValid = 1'b1; InData = 3'b100; OutReady = 1'b1;
        @(negedge Clk);
        chk("sim_load_we", RamWrite, 0);
        chk("sim_load_rdy", InReady, 0);
        next_cycle();
        OutReady = 1'b0;
        @(negedge Clk);
        chk("sim_next_rdy", InReady, 1);
        chk("sim_next_we", RamWrite, 1);
`ifndef RAM4X3_FIFO_BYPASS_EN
        chk("sim_next_addr", RamAddr, m_wr);
        m_wr = m_wr + 2'd1;
`endif
        exp_q.push_back(3'b100);
        next_cycle();
        InValid = 1'b0;
        OutReady = 1'b1;
        wait_empty();
        chk("sim_pops", pops, 19);
        OutReady = 1'b0;

        // Latency from an empty FIFO with the consumer stalled.
        InValid = 1'b1; InData = 3'b110;
        @(negedge Clk);
        chk("lat_inready", InReady, 1);
`ifdef RAM4X3_FIFO_BYPASS_EN
        chk("byp_we0", RamWrite, 0);
`else
        chk("lat_we", RamWrite, 1);
`endif
        exp_q.push_back(3'b110);
        next_cycle();
        InValid = 1'b0;
        @(negedge Clk);
`ifdef RAM4X3_FIFO_BYPASS_EN
        chk("byp_outvalid", OutValid, 1);
        chk("byp_outdata", OutData, 3'b110);
        chk("byp_count", Count, 0);
        chk("byp_we1", RamWrite, 0);
`else
        chk("lat_outvalid_n1", OutValid, 0);
        chk("lat_count_n1", Count, 1);
        next_cycle();
        @(negedge Clk);
        chk("lat_outvalid_n2", OutValid, 1);
        chk("lat_outdata_n2", OutData, 3'b110);
        chk("lat_count_n2", Count, 0);
`endif
        next_cycle();
        OutReady = 1'b1;
        wait_empty();
        chk("lat_pops", pops, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
